// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver: the FSM
// state encoding, the data width and the idle line level.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Fractional baud tick generator: one tick per bit time with no cumulative
// drift. The accumulator is held at zero whenever en is low.
module uart_tx_baud_gen #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int AccWidth = $clog2(ClkFrequency + Baud);
  localparam logic [AccWidth-1:0] BaudInc  = AccWidth'(Baud);
  localparam logic [AccWidth-1:0] ClkLimit = AccWidth'(ClkFrequency);

  logic [AccWidth-1:0] acc_q;
  logic [AccWidth-1:0] sum;

  // The sum stays below ClkFrequency + Baud, so it fits in AccWidth bits.
  assign sum  = acc_q + BaudInc;
  assign tick = en && (sum >= ClkLimit);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc_q <= '0;
    end else if (tick) begin
      acc_q <= sum - ClkLimit;
    end else begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one byte per request, sent LSB first as an 8-N-1 or
// 8-N-2 frame. Defining UART_TX_PARITY_EN adds a parity bit whose sense is set
// by ParityOdd.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int StopBits     = 1,
  parameter int ParityOdd    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              TxD_start,
  input  logic [DATA_W-1:0] TxD_data,
  output logic              TxD_busy,
  output logic              TxD_out
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_W - 1);
  localparam logic                 STOP_LAST = 1'(StopBits - 1);

  if (StopBits < 1 || StopBits > 2 || ParityOdd < 0 || ParityOdd > 1) begin : g_bad_cfg
    $error("uart_tx_framer: StopBits must be 1 or 2, ParityOdd must be 0 or 1");
  end

  uart_state_e           state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_d, busy_d;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  uart_tx_baud_gen #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .en  (TxD_busy),
    .tick(tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      TxD_out    <= IDLE_LEVEL;
      TxD_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      TxD_out    <= tx_d;
      TxD_busy   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (TxD_start && !TxD_busy) begin
          state_d = ST_START;
          shift_d = TxD_data;
`ifdef UART_TX_PARITY_EN
          parity_d = (^TxD_data) ^ ParityOdd[0];
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes
  // on the same edge as the state it belongs to.
  always_comb begin
    tx_d   = IDLE_LEVEL;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer at 1 MHz / 100 kBd (10 clk per bit).
// Build with UART_TX_PARITY_EN defined to cover the parity frame format.
module tb_uart_tx_framer;

  localparam int ClkFreq  = 1000000;
  localparam int BaudRate = 100000;
  localparam int BitClks  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif
  localparam int FrameClks = BitClks * (10 + ParBits);

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, d7..d0, start}; bit 0 goes out first
    logic       par;    // even parity bit
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx_out, busy;

  int checks = 0;
  int failures = 0;

  uart_tx_framer #(
    .ClkFrequency(ClkFreq),
    .Baud        (BaudRate),
    .StopBits    (1),
    .ParityOdd   (0)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .TxD_start(start),
    .TxD_data (data),
    .TxD_busy (busy),
    .TxD_out  (tx_out)
  );

`ifdef UART_TX_PARITY_EN
  logic       start_o = 1'b0;
  logic [7:0] data_o = 8'h00;
  logic       tx_out_o, busy_o;

  uart_tx_framer #(
    .ClkFrequency(ClkFreq),
    .Baud        (BaudRate),
    .StopBits    (1),
    .ParityOdd   (1)
  ) u_dut_odd (
    .clk      (clk),
    .rst      (rst),
    .TxD_start(start_o),
    .TxD_data (data_o),
    .TxD_busy (busy_o),
    .TxD_out  (tx_out_o)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_line(input logic [9:0] fr, input logic par, input int c);
    int b;
    b = c / BitClks;
    if (b < 9) return fr[b];
    if (ParBits == 1 && b == 9) return par;
    return fr[9];
  endfunction

  // Pulses a request for one cycle; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    data  = ~d;
  endtask

  // Checks every clk of a frame starting at the negedge after accept, then
  // the idle-high cycle that follows it. A request is pulsed at cycle pulse_at.
  task automatic run_frame(input logic [9:0] fr, input logic par, input string name,
                           input int pulse_at);
    for (int c = 0; c < FrameClks; c++) begin
      check($sformatf("%s line c%0d", name, c), 32'(tx_out), 32'(exp_line(fr, par, c)));
      check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd1);
      if (c == pulse_at) begin
        start = 1'b1;
        data  = 8'h3C;
      end else if (c == pulse_at + 1) begin
        start = 1'b0;
        data  = 8'h00;
      end
      @(negedge clk);
    end
    check($sformatf("%s end line", name), 32'(tx_out), 32'd1);
    check($sformatf("%s end busy", name), 32'(busy), 32'd0);
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s line i%0d", name, i), 32'(tx_out), 32'd1);
      check($sformatf("%s busy i%0d", name, i), 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[1] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[2] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
    vecs[3] = '{8'h80, 10'b1_1000_0000_0, 1'b1};
    vecs[4] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
    vecs[5] = '{8'h00, 10'b1_0000_0000_0, 1'b0};

    // Reset for three cycles, then a quiet line.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("reset line", 32'(tx_out), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle_cycles("quiet", 200);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data);
      run_frame(vecs[v].frame, vecs[v].par, $sformatf("vec%0d", v), -10);
      idle_cycles($sformatf("vec%0d gap", v), 3);
    end

    // Request held high: 8'h00 then 8'hFF with a single idle cycle between.
    start = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    data = 8'hFF;
    run_frame(10'b1_0000_0000_0, 1'b0, "b2b first", -10);
    @(negedge clk);
    start = 1'b0;
    data  = 8'h00;
    run_frame(10'b1_1111_1111_0, 1'b0, "b2b second", -10);
    idle_cycles("b2b after", 5);

    // Request while busy is dropped, not queued.
    send(8'h55);
    run_frame(10'b1_0101_0101_0, 1'b0, "busy req", 35);
    idle_cycles("busy req after", 30);

    // Reset in the middle of the data bits abandons the frame.
    send(8'h81);
    for (int c = 0; c < 45; c++) begin
      check($sformatf("abort line c%0d", c), 32'(tx_out),
            32'(exp_line(10'b1_1000_0001_0, 1'b0, c)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort rst line", 32'(tx_out), 32'd1);
    check("abort rst busy", 32'(busy), 32'd0);
    idle_cycles("abort idle", 5);
    send(8'h12);
    run_frame(10'b1_0001_0010_0, 1'b0, "after abort", -10);

    // Reset and request on the same edge: the request is lost.
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h5A;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    idle_cycles("rst+start", 15);

`ifdef UART_TX_PARITY_EN
    // Odd parity for 8'h07 (three ones) gives a parity bit of 0.
    start_o = 1'b1;
    data_o  = 8'h07;
    @(negedge clk);
    start_o = 1'b0;
    data_o  = 8'h00;
    for (int c = 0; c < FrameClks; c++) begin
      check($sformatf("odd line c%0d", c), 32'(tx_out_o),
            32'(exp_line(10'b1_0000_0111_0, 1'b0, c)));
      check($sformatf("odd busy c%0d", c), 32'(busy_o), 32'd1);
      @(negedge clk);
    end
    check("odd end busy", 32'(busy_o), 32'd0);
    check("odd end line", 32'(tx_out_o), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
